// File: rtl/rst_seq_gen_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and a
// small elaboration-time helper.
package rst_seq_gen_pkg;

    localparam logic [1:0] HOLD    = 2'd0;
    localparam logic [1:0] RELEASE = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync_bit.sv
// Single-bit synchronizer whose flops are forced to INIT by an asynchronous
// reset and released only through the clocked chain.
module rst_sync_bit #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {STAGES{INIT}};
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: merges async reset, filtered sync request and clock lock,
// then releases rst_out[0..NUM_OUT-1] in order with a fixed gap.
module rst_seq_gen
    import rst_seq_gen_pkg::*;
#(
    parameter int NUM_OUT       = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int POR_CYCLES    = 255,
    parameter int STAGE_GAP     = 16,
    parameter int FILTER_CYCLES = 4,
    parameter int USE_LOCKED    = 1
) (
    input  logic                                   clk,
    input  logic                                   async_rst_src,
    input  logic                                   sync_rst_src,
    input  logic                                   locked,
    (* keep = "true" *) output logic [NUM_OUT-1:0] rst_out,
    (* keep = "true" *) output logic               rst_done
);

    localparam int CNT_W = $clog2(max_int(POR_CYCLES, STAGE_GAP) + 1);
    localparam int STG_W = $clog2(NUM_OUT + 1);
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);

    logic               arm;
    logic               locked_sync;
    logic [FLT_W-1:0]   flt_cnt;
    logic               flt_req;
    logic               lock_req;
    logic               qual;
    logic [1:0]         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [STG_W-1:0]   stage, stage_nxt;
    logic [NUM_OUT-1:0] rst_out_nxt;
    logic               rst_done_nxt;

    rst_sync_bit #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_arm_sync (
        .clk (clk),
        .rst (async_rst_src),
        .d   (1'b0),
        .q   (arm)
    );

    // Lock is treated as lost until it has crossed the chain after reset.
    rst_sync_bit #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_lock_sync (
        .clk (clk),
        .rst (async_rst_src),
        .d   (locked),
        .q   (locked_sync)
    );

    // Saturating run-length of high samples; request holds while input stays high.
    always_ff @(posedge clk or posedge async_rst_src) begin
        if (async_rst_src) begin
            flt_cnt <= '0;
        end else if (!sync_rst_src) begin
            flt_cnt <= '0;
        end else if (!flt_req) begin
            flt_cnt <= flt_cnt + FLT_W'(1);
        end
    end

    assign flt_req  = (flt_cnt == FLT_W'(FILTER_CYCLES));
    assign lock_req = (USE_LOCKED != 0) && !locked_sync;
    assign qual     = !arm && !flt_req && !lock_req;

    always_ff @(posedge clk or posedge async_rst_src) begin
        if (async_rst_src) begin
            state    <= HOLD;
            cnt      <= '0;
            stage    <= '0;
            rst_out  <= '1;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            stage    <= stage_nxt;
            rst_out  <= rst_out_nxt;
            rst_done <= rst_done_nxt;
        end
    end

    // A request or unarmed edge always wins over a terminal count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        stage_nxt = stage;
        if (!qual) begin
            state_nxt = HOLD;
            stage_nxt = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == CNT_W'(POR_CYCLES - 1)) begin
                        stage_nxt = STG_W'(1);
                        state_nxt = (NUM_OUT == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                        stage_nxt = stage + STG_W'(1);
                        if (stage_nxt == STG_W'(NUM_OUT)) begin
                            state_nxt = RUN;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = HOLD;
                    stage_nxt = '0;
                end
            endcase
        end
    end

    // stage counts released bits, so outputs are always a low-index prefix of zeros.
    always_comb begin
        rst_out_nxt = '1;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (STG_W'(i) < stage_nxt) begin
                rst_out_nxt[i] = 1'b0;
            end
        end
        rst_done_nxt = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: one instance honouring locked, one ignoring it (locked tied low),
// both checked against a release-time model driven by streaks of qualifying edges.
module tb_rst_seq_gen;

    localparam int N   = 3;
    localparam int SY  = 2;
    localparam int POR = 8;
    localparam int GAP = 4;
    localparam int FLT = 4;

    logic         clk = 1'b0;
    logic         async_rst_src = 1'b0;
    logic         sync_rst_src = 1'b0;
    logic         locked = 1'b1;
    logic [N-1:0] out1, out2;
    logic         done1, done2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rst_seq_gen #(.NUM_OUT(N), .SYNC_STAGES(SY), .POR_CYCLES(POR), .STAGE_GAP(GAP),
                  .FILTER_CYCLES(FLT), .USE_LOCKED(1)) dut_lk (
        .clk(clk), .async_rst_src(async_rst_src), .sync_rst_src(sync_rst_src),
        .locked(locked), .rst_out(out1), .rst_done(done1));

    rst_seq_gen #(.NUM_OUT(N), .SYNC_STAGES(SY), .POR_CYCLES(POR), .STAGE_GAP(GAP),
                  .FILTER_CYCLES(FLT), .USE_LOCKED(0)) dut_nl (
        .clk(clk), .async_rst_src(async_rst_src), .sync_rst_src(sync_rst_src),
        .locked(1'b0), .rst_out(out2), .rst_done(done2));

    // Model: released bit count follows from the length of the current qualifying streak.
    int           since_m[2];
    int           hi_m[2];
    int           streak_m[2];
    logic [SY-1:0] lhist_m[2];
    logic [N-1:0] exp_out[2];
    logic         exp_done[2];

    function automatic void model_outputs(int m);
        int r;
        logic [N-1:0] ones;
        ones = '1;
        r = (streak_m[m] < POR) ? 0 : 1 + (streak_m[m] - POR) / GAP;
        if (r > N) r = N;
        exp_out[m]  = ones << r;
        exp_done[m] = (r == N);
    endfunction

    function automatic void model_reset(int m);
        since_m[m]  = 0;
        hi_m[m]     = 0;
        streak_m[m] = 0;
        lhist_m[m]  = '0;
        model_outputs(m);
    endfunction

    function automatic void model_edge(int m, logic a, logic s, logic l, bit use_lk);
        bit arm_low, lsync, req;
        if (a) begin
            model_reset(m);
        end else begin
            arm_low = (since_m[m] >= SY);
            lsync   = lhist_m[m][SY-1];
            req     = (hi_m[m] >= FLT) || (use_lk && !lsync);
            streak_m[m] = (arm_low && !req) ? ((streak_m[m] < 100000) ? streak_m[m] + 1 : streak_m[m]) : 0;
            if (since_m[m] < SY) since_m[m] = since_m[m] + 1;
            lhist_m[m] = {lhist_m[m][SY-2:0], l};
            hi_m[m]    = s ? ((hi_m[m] < 1000) ? hi_m[m] + 1 : hi_m[m]) : 0;
            model_outputs(m);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(0, async_rst_src, sync_rst_src, locked, 1'b1);
        model_edge(1, async_rst_src, sync_rst_src, 1'b0, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        #1 async_rst_src = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        nvec++;
        if (out1 !== 3'b111 || done1 !== 1'b0 || out2 !== 3'b111 || done2 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_immediate got %b/%b %b/%b want 111/0", out1, done1, out2, done2);
        end
        repeat (3) begin
            tick();
            nvec++;
            if ({out1, done1, out2, done2} !== {exp_out[0], exp_done[0], exp_out[1], exp_done[1]}) begin
                nerr++;
                $display("FAIL reset_hold got %b/%b %b/%b want %b/%b %b/%b", out1, done1, out2, done2,
                         exp_out[0], exp_done[0], exp_out[1], exp_done[1]);
            end
        end
        async_rst_src = 1'b0;
    endtask

    task automatic test_async_midrun();
        logic [N-1:0] want;
        logic         wdone;
        repeat (30) begin
            tick();
            nvec++;
            if ({out1, done1, out2, done2} !== {exp_out[0], exp_done[0], exp_out[1], exp_done[1]}) begin
                nerr++;
                $display("FAIL power_on got %b/%b %b/%b want %b/%b %b/%b", out1, done1, out2, done2,
                         exp_out[0], exp_done[0], exp_out[1], exp_done[1]);
            end
        end
        async_rst_src = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        nvec++;
        if (out1 !== 3'b111 || done1 !== 1'b0 || out2 !== 3'b111 || done2 !== 1'b0) begin
            nerr++;
            $display("FAIL async_immediate got %b/%b %b/%b want 111/0", out1, done1, out2, done2);
        end
        tick();
        async_rst_src = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            want  = (e < 10) ? 3'b111 : (e < 14) ? 3'b110 : (e < 18) ? 3'b100 : 3'b000;
            wdone = (e >= 18);
            nvec++;
            if (out1 !== want || done1 !== wdone || out2 !== want || done2 !== wdone) begin
                nerr++;
                $display("FAIL por_timing edge=%0d got %b/%b %b/%b want %b/%b", e, out1, done1, out2, done2, want, wdone);
            end
            nvec++;
            if ({out1, done1, out2, done2} !== {exp_out[0], exp_done[0], exp_out[1], exp_done[1]}) begin
                nerr++;
                $display("FAIL por_model edge=%0d got %b/%b %b/%b want %b/%b %b/%b", e, out1, done1, out2, done2,
                         exp_out[0], exp_done[0], exp_out[1], exp_done[1]);
            end
        end
    endtask

    task automatic test_sync_filter();
        logic [N-1:0] want;
        int len, gap;
        for (int k = 0; k < 7; k++) begin
            sync_rst_src = (k < 3);
            tick();
            nvec++;
            if (out1 !== 3'b000 || done1 !== 1'b1 || out2 !== 3'b000 || done2 !== 1'b1) begin
                nerr++;
                $display("FAIL short_pulse k=%0d got %b/%b %b/%b want 000/1", k, out1, done1, out2, done2);
            end
        end
        for (int k = 0; k < 4; k++) begin
            sync_rst_src = 1'b1;
            tick();
            nvec++;
            if (out1 !== 3'b000 || out2 !== 3'b000) begin
                nerr++;
                $display("FAIL filter_early k=%0d got %b %b want 000", k, out1, out2);
            end
        end
        sync_rst_src = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            want = (k < 9) ? 3'b111 : 3'b110;
            nvec++;
            if (out1 !== want || done1 !== 1'b0 || out2 !== want || done2 !== 1'b0) begin
                nerr++;
                $display("FAIL filter_req k=%0d got %b/%b %b/%b want %b/0", k, out1, done1, out2, done2, want);
            end
        end
        for (int b = 0; b < 15; b++) begin
            len = $urandom_range(1, 6);
            gap = $urandom_range(1, 25);
            for (int k = 0; k < len + gap; k++) begin
                sync_rst_src = (k < len);
                tick();
                nvec++;
                if ({out1, done1, out2, done2} !== {exp_out[0], exp_done[0], exp_out[1], exp_done[1]}) begin
                    nerr++;
                    $display("FAIL filter_rand b=%0d k=%0d got %b/%b %b/%b want %b/%b %b/%b", b, k, out1, done1, out2, done2,
                             exp_out[0], exp_done[0], exp_out[1], exp_done[1]);
                end
            end
        end
        sync_rst_src = 1'b0;
    endtask

    task automatic test_lock_loss();
        logic [N-1:0] want1, want2;
        async_rst_src = 1'b1;
        model_reset(0);
        model_reset(1);
        tick();
        async_rst_src = 1'b0;
        for (int e = 1; e <= 26; e++) begin
            if (e == 12) locked = 1'b0;
            if (e == 15) locked = 1'b1;
            tick();
            nvec++;
            if ({out1, done1, out2, done2} !== {exp_out[0], exp_done[0], exp_out[1], exp_done[1]}) begin
                nerr++;
                $display("FAIL lock_model edge=%0d got %b/%b %b/%b want %b/%b %b/%b", e, out1, done1, out2, done2,
                         exp_out[0], exp_done[0], exp_out[1], exp_done[1]);
            end
            if (e >= 11) begin
                want1 = (e < 14) ? 3'b110 : (e < 24) ? 3'b111 : 3'b110;
                want2 = (e < 14) ? 3'b110 : (e < 18) ? 3'b100 : 3'b000;
                nvec++;
                if (out1 !== want1 || out2 !== want2) begin
                    nerr++;
                    $display("FAIL lock_timing edge=%0d got %b %b want %b %b", e, out1, out2, want1, want2);
                end
            end
        end
    endtask

    task automatic test_terminal_req();
        logic [N-1:0] want;
        async_rst_src = 1'b1;
        model_reset(0);
        model_reset(1);
        tick();
        async_rst_src = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            sync_rst_src = (e >= 6 && e <= 9);
            tick();
            want = (e < 18) ? 3'b111 : 3'b110;
            nvec++;
            if (out1 !== want || out2 !== want || done1 !== 1'b0 || done2 !== 1'b0) begin
                nerr++;
                $display("FAIL terminal_req edge=%0d got %b/%b %b/%b want %b/0", e, out1, done1, out2, done2, want);
            end
        end
        sync_rst_src = 1'b0;
    endtask

    task automatic test_async_mid_release();
        async_rst_src = 1'b1;
        model_reset(0);
        model_reset(1);
        tick();
        async_rst_src = 1'b0;
        repeat (15) tick();
        nvec++;
        if (out1 !== 3'b100 || out2 !== 3'b100) begin
            nerr++;
            $display("FAIL mid_release_pre got %b %b want 100", out1, out2);
        end
        #1 async_rst_src = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        nvec++;
        if (out1 !== 3'b111 || done1 !== 1'b0 || out2 !== 3'b111 || done2 !== 1'b0) begin
            nerr++;
            $display("FAIL mid_release_async got %b/%b %b/%b want 111/0", out1, done1, out2, done2);
        end
        repeat (2) tick();
        async_rst_src = 1'b0;
        repeat (25) begin
            tick();
            nvec++;
            if ({out1, done1, out2, done2} !== {exp_out[0], exp_done[0], exp_out[1], exp_done[1]}) begin
                nerr++;
                $display("FAIL mid_release_model got %b/%b %b/%b want %b/%b %b/%b", out1, done1, out2, done2,
                         exp_out[0], exp_done[0], exp_out[1], exp_done[1]);
            end
            nvec++;
            if (!(out1 inside {3'b111, 3'b110, 3'b100, 3'b000}) || !(out2 inside {3'b111, 3'b110, 3'b100, 3'b000})) begin
                nerr++;
                $display("FAIL prefix got %b %b want ones-prefix", out1, out2);
            end
        end
    endtask

    task automatic test_random();
        int async_left = 0;
        int sync_left  = 0;
        int lock_left  = 0;
        for (int i = 0; i < 3000; i++) begin
            if (async_left > 0) begin
                async_left--;
                if (async_left == 0) async_rst_src = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                async_left = $urandom_range(1, 3);
                async_rst_src = 1'b1;
                model_reset(0);
                model_reset(1);
                #1;
                nvec++;
                if (out1 !== 3'b111 || done1 !== 1'b0 || out2 !== 3'b111 || done2 !== 1'b0) begin
                    nerr++;
                    $display("FAIL rand_async i=%0d got %b/%b %b/%b want 111/0", i, out1, done1, out2, done2);
                end
            end
            if (sync_left > 0) begin
                sync_rst_src = 1'b1;
                sync_left--;
            end else begin
                sync_rst_src = 1'b0;
                if ($urandom_range(0, 14) == 0) sync_left = $urandom_range(1, 6);
            end
            if (lock_left > 0) begin
                locked = 1'b0;
                lock_left--;
            end else begin
                locked = 1'b1;
                if ($urandom_range(0, 149) == 0) lock_left = $urandom_range(1, 10);
            end
            tick();
            nvec++;
            if ({out1, done1, out2, done2} !== {exp_out[0], exp_done[0], exp_out[1], exp_done[1]}) begin
                nerr++;
                $display("FAIL rand_model i=%0d got %b/%b %b/%b want %b/%b %b/%b", i, out1, done1, out2, done2,
                         exp_out[0], exp_done[0], exp_out[1], exp_done[1]);
            end
            nvec++;
            if (!(out1 inside {3'b111, 3'b110, 3'b100, 3'b000}) || !(out2 inside {3'b111, 3'b110, 3'b100, 3'b000})) begin
                nerr++;
                $display("FAIL rand_prefix i=%0d got %b %b want ones-prefix", i, out1, out2);
            end
        end
        async_rst_src = 1'b0;
        sync_rst_src  = 1'b0;
        locked        = 1'b1;
    endtask

    initial begin
        test_reset();
        test_async_midrun();
        test_sync_filter();
        test_lock_loss();
        test_terminal_req();
        test_async_mid_release();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
